// File: rtl/score_bank_mux_pkg.sv
`default_nettype none
// ============================================================================
// score_bank_mux_pkg : shared FSM encoding and sizing helpers for the bank
// Revision: 1.0
// ============================================================================
package score_bank_mux_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    LATCH = 2'd2
  } bank_state_e;

  // A single slot still needs a 1-bit index port.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // All-ones "empty" marker of width w, truncated by the caller (w <= 64).
  function automatic logic [63:0] empty_of(input int w);
    return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/score_min_scanner.sv
`default_nettype none
// ============================================================================
// score_min_scanner : walks the slot values one per cycle, keeps min/argmin
// Revision: 1.0
// ============================================================================
module score_min_scanner
  import score_bank_mux_pkg::*;
#(
  parameter  int WIDTH     = 24,
  parameter  int NUM_SLOTS = 2,
  localparam int SEL_W     = sel_width(NUM_SLOTS)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start_i,
  input  logic [NUM_SLOTS*WIDTH-1:0] vals_i,
  output logic                       last_o,
  output logic                       done_o,
  output logic [WIDTH-1:0]           min_o,
  output logic [SEL_W-1:0]           argmin_o
);

  localparam logic [WIDTH-1:0] EMPTY    = WIDTH'(empty_of(WIDTH));
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_SLOTS - 1);

  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [SEL_W-1:0] arg_q, arg_d;
  logic [WIDTH-1:0] min_q, min_d;
  logic [WIDTH-1:0] cur;
  logic             last;

  always_comb begin
    cur = EMPTY;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (idx_q == SEL_W'(i)) cur = vals_i[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    busy_d = busy_q;
    idx_d  = idx_q;
    min_d  = min_q;
    arg_d  = arg_q;
    done_d = 1'b0;
    last   = busy_q && (idx_q == LAST_IDX);
    if (start_i) begin
      busy_d = 1'b1;
      idx_d  = '0;
      min_d  = EMPTY;
      arg_d  = '0;
    end else if (busy_q) begin
      // Strict compare: the lowest index keeps a tie, and EMPTY never wins.
      if (cur < min_q) begin
        min_d = cur;
        arg_d = idx_q;
      end
      if (last) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end else begin
        idx_d = idx_q + SEL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      idx_q  <= '0;
      arg_q  <= '0;
      min_q  <= EMPTY;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      idx_q  <= idx_d;
      arg_q  <= arg_d;
      min_q  <= min_d;
    end
  end

  assign last_o   = last;
  assign done_o   = done_q;
  assign min_o    = min_q;
  assign argmin_o = arg_q;

endmodule
`default_nettype wire

// File: rtl/score_bank_mux.sv
`default_nettype none
// ============================================================================
// score_bank_mux : per-slot best-score bank with overall-best scan and display mux
// Revision: 1.0
// ============================================================================
module score_bank_mux
  import score_bank_mux_pkg::*;
#(
  parameter  int WIDTH     = 24,
  parameter  int NUM_SLOTS = 2,
  localparam int SEL_W     = sel_width(NUM_SLOTS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] score_in,
  input  logic             score_valid,
  input  logic             clear_slot,
  input  logic [SEL_W-1:0] slot_in,
  output logic             ready,
  output logic             new_record,
  input  logic [SEL_W-1:0] disp_sel,
  input  logic             disp_mode,
  output logic [WIDTH-1:0] disp_out,
  output logic [SEL_W-1:0] best_slot
);

  localparam logic [WIDTH-1:0] EMPTY = WIDTH'(empty_of(WIDTH));

  bank_state_e state_q, state_d;

  logic [WIDTH-1:0]           best_q [NUM_SLOTS];
  logic [NUM_SLOTS*WIDTH-1:0] vals;
  logic [WIDTH-1:0]           overall_q;
  logic [SEL_W-1:0]           best_slot_q;
  logic [WIDTH-1:0]           disp_q;
  logic                       rec_q, rec_d;

  logic             slot_ok;
  logic [WIDTH-1:0] cur_best;
  logic [WIDTH-1:0] disp_sel_val;
  logic             wr_en;
  logic [WIDTH-1:0] wr_val;
  logic             scan_start;
  logic             scan_last;
  logic             scan_done;
  logic [WIDTH-1:0] scan_min;
  logic [SEL_W-1:0] scan_arg;

  generate
    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_flat
      assign vals[g*WIDTH +: WIDTH] = best_q[g];
    end
  endgenerate

  // Loop-based lookups so an out-of-range index reads EMPTY, never X.
  always_comb begin
    slot_ok      = int'(slot_in) < NUM_SLOTS;
    cur_best     = EMPTY;
    disp_sel_val = EMPTY;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (int'(slot_in) == i)  cur_best     = best_q[i];
      if (int'(disp_sel) == i) disp_sel_val = best_q[i];
    end
  end

  always_comb begin
    state_d    = state_q;
    wr_en      = 1'b0;
    wr_val     = score_in;
    rec_d      = 1'b0;
    scan_start = 1'b0;
    case (state_q)
      IDLE: begin
        if ((score_valid || clear_slot) && slot_ok) begin
          if (clear_slot) begin
            wr_en      = 1'b1;
            wr_val     = EMPTY;
            scan_start = 1'b1;
            state_d    = SCAN;
          end else if (score_in < cur_best) begin
            wr_en      = 1'b1;
            rec_d      = 1'b1;
            scan_start = 1'b1;
            state_d    = SCAN;
          end
        end
      end
      SCAN:    if (scan_last) state_d = LATCH;
      LATCH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rec_q       <= 1'b0;
      overall_q   <= EMPTY;
      best_slot_q <= '0;
      disp_q      <= EMPTY;
      for (int i = 0; i < NUM_SLOTS; i++) best_q[i] <= EMPTY;
    end else begin
      state_q <= state_d;
      rec_q   <= rec_d;
      disp_q  <= disp_mode ? overall_q : disp_sel_val;
      if ((state_q == LATCH) && scan_done) begin
        overall_q   <= scan_min;
        best_slot_q <= scan_arg;
      end
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (wr_en && (int'(slot_in) == i)) best_q[i] <= wr_val;
      end
    end
  end

  score_min_scanner #(
    .WIDTH    (WIDTH),
    .NUM_SLOTS(NUM_SLOTS)
  ) u_scan (
    .clk     (clk),
    .reset   (reset),
    .start_i (scan_start),
    .vals_i  (vals),
    .last_o  (scan_last),
    .done_o  (scan_done),
    .min_o   (scan_min),
    .argmin_o(scan_arg)
  );

  assign ready      = (state_q == IDLE);
  assign new_record = rec_q;
  assign disp_out   = disp_q;
  assign best_slot  = best_slot_q;

endmodule
`default_nettype wire

// File: tb/tb_score_bank_mux.sv
`default_nettype none
// ============================================================================
// tb_score_bank_mux : directed + random checks of 2-slot and 5-slot banks
// Revision: 1.0
// ============================================================================
module tb_score_bank_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // Instance A: 2 slots
  logic        a_sv, a_clr, a_mode;
  logic [0:0]  a_slot, a_dsel, a_bslot;
  logic [23:0] a_score, a_disp;
  logic        a_ready, a_rec;
  // Instance B: 5 slots
  logic        b_sv, b_clr, b_mode;
  logic [2:0]  b_slot, b_dsel, b_bslot;
  logic [23:0] b_score, b_disp;
  logic        b_ready, b_rec;

  score_bank_mux #(.WIDTH(24), .NUM_SLOTS(2)) dut_a (
    .clk(clk), .reset(rst), .score_in(a_score), .score_valid(a_sv),
    .clear_slot(a_clr), .slot_in(a_slot), .ready(a_ready), .new_record(a_rec),
    .disp_sel(a_dsel), .disp_mode(a_mode), .disp_out(a_disp), .best_slot(a_bslot)
  );

  score_bank_mux #(.WIDTH(24), .NUM_SLOTS(5)) dut_b (
    .clk(clk), .reset(rst), .score_in(b_score), .score_valid(b_sv),
    .clear_slot(b_clr), .slot_in(b_slot), .ready(b_ready), .new_record(b_rec),
    .disp_sel(b_dsel), .disp_mode(b_mode), .disp_out(b_disp), .best_slot(b_bslot)
  );

  int ncmp = 0;
  int nfail = 0;
  logic [23:0] bm [2][5];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int ns(input int d);
    return (d == 0) ? 2 : 5;
  endfunction

  function automatic logic [31:0] rdy(input int d);
    return (d == 0) ? 32'(a_ready) : 32'(b_ready);
  endfunction
  function automatic logic [31:0] rec(input int d);
    return (d == 0) ? 32'(a_rec) : 32'(b_rec);
  endfunction
  function automatic logic [31:0] disp(input int d);
    return (d == 0) ? 32'(a_disp) : 32'(b_disp);
  endfunction
  function automatic logic [31:0] bslot(input int d);
    return (d == 0) ? 32'(a_bslot) : 32'(b_bslot);
  endfunction

  // Reference: overall best is the smallest value, earliest slot on ties.
  function automatic int ref_idx(input int d);
    logic [23:0] m;
    int k;
    m = 24'hFFFFFF;
    k = 0;
    for (int i = 0; i < ns(d); i++)
      if (bm[d][i] < m) begin m = bm[d][i]; k = i; end
    return k;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 5; i++) bm[d][i] = 24'hFFFFFF;
  endtask

  task automatic drive(input int d, input bit sv, input bit cl, input int slot, input logic [23:0] sc);
    if (d == 0) begin a_sv = sv; a_clr = cl; a_slot = slot[0:0]; a_score = sc; end
    else        begin b_sv = sv; b_clr = cl; b_slot = slot[2:0]; b_score = sc; end
  endtask

  task automatic set_disp(input int d, input bit mode, input int sel);
    if (d == 0) begin a_mode = mode; a_dsel = sel[0:0]; end
    else        begin b_mode = mode; b_dsel = sel[2:0]; end
  endtask

  task automatic chk_disp(input int d, input string tag);
    set_disp(d, 1'b1, 0);
    @(negedge clk);
    @(negedge clk);
    chk({tag, " disp overall"}, disp(d), 32'(bm[d][ref_idx(d)]));
    for (int i = 0; i < ns(d); i++) begin
      set_disp(d, 1'b0, i);
      @(negedge clk);
      chk($sformatf("%s disp slot%0d", tag, i), disp(d), 32'(bm[d][i]));
    end
  endtask

  task automatic req(input int d, input bit sv, input bit cl, input int slot,
                     input logic [23:0] sc, input string tag);
    bit upd, rc;
    int lowc;
    upd = 1'b0;
    rc  = 1'b0;
    if ((sv || cl) && slot < ns(d)) begin
      if (cl) begin
        upd = 1'b1;
        bm[d][slot] = 24'hFFFFFF;
      end else if (sc < bm[d][slot]) begin
        upd = 1'b1;
        rc  = 1'b1;
        bm[d][slot] = sc;
      end
    end
    @(negedge clk);
    chk({tag, " ready idle"}, rdy(d), 32'd1);
    drive(d, sv, cl, slot, sc);
    @(negedge clk);
    drive(d, 1'b0, 1'b0, 0, 24'd0);
    chk({tag, " new_record"}, rec(d), 32'(rc));
    lowc = 0;
    for (int k = 0; k < 20 && rdy(d) == 32'd0; k++) begin
      lowc++;
      @(negedge clk);
    end
    chk({tag, " ready low cycles"}, 32'(lowc), upd ? 32'(ns(d) + 1) : 32'd0);
    chk({tag, " pulse ended"}, rec(d), 32'd0);
    chk({tag, " best_slot"}, bslot(d), 32'(ref_idx(d)));
  endtask

  int          slot, pick;
  logic [23:0] sc;
  bit          cl, sv;

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 24'd0);
    drive(1, 0, 0, 0, 24'd0);
    set_disp(0, 1'b0, 0);
    set_disp(1, 1'b0, 0);
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset ready A", rdy(0), 32'd1);
    chk("reset disp A", disp(0), 32'hFFFFFF);
    chk("reset best_slot A", bslot(0), 32'd0);
    chk("reset new_record A", rec(0), 32'd0);
    chk("reset ready B", rdy(1), 32'd1);
    chk("reset disp B", disp(1), 32'hFFFFFF);
    rst = 1'b0;

    // Reset arriving mid-scan
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 1, 24'h000250);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 0, 24'd0);
    chk("midscan busy", rdy(0), 32'd0);
    rst = 1'b1;
    #1;
    chk("midscan reset ready", rdy(0), 32'd1);
    chk("midscan reset best_slot", bslot(0), 32'd0);
    chk("midscan reset disp", disp(0), 32'hFFFFFF);
    chk("midscan reset rec", rec(0), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    chk_disp(0, "after reset");

    // Records and scan
    req(0, 1, 0, 0, 24'h000300, "rec s0");
    req(0, 1, 0, 1, 24'h000250, "rec s1");
    chk_disp(0, "rec");
    // Tie and non-record
    req(0, 1, 0, 0, 24'h000300, "tie s0");
    req(0, 1, 0, 0, 24'h000400, "worse s0");
    req(0, 1, 0, 0, 24'hFFFFFF, "empty score");
    chk_disp(0, "nonrec");
    // Tie across slots
    req(0, 1, 0, 1, 24'h000123, "xtie s1");
    req(0, 1, 0, 0, 24'h000123, "xtie s0");
    // Clear wins over a simultaneous score
    req(0, 1, 1, 1, 24'h000100, "clear s1");
    chk_disp(0, "clear");

    // 5-slot instance: out-of-range request and display, then scan
    req(1, 1, 0, 7, 24'h000010, "oor req");
    set_disp(1, 1'b0, 6);
    @(negedge clk);
    @(negedge clk);
    chk("oor disp", disp(1), 32'hFFFFFF);
    req(1, 1, 0, 4, 24'h000500, "b s4");
    req(1, 1, 0, 2, 24'h000200, "b s2");
    chk_disp(1, "b scan");

    // Randomized traffic against the reference model
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 40; n++) begin
        slot = $urandom_range(0, (d == 0) ? 1 : 7);
        pick = $urandom_range(0, 9);
        sc   = (pick == 0) ? 24'hFFFFFF : 24'($urandom_range(0, 32'h3FF));
        cl   = (pick == 1);
        sv   = (pick != 2);
        req(d, sv, cl, slot, sc, $sformatf("rand d%0d n%0d", d, n));
        if (n % 5 == 4) chk_disp(d, $sformatf("rand d%0d n%0d", d, n));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
`default_nettype wire
